rtc_bus_engine: RTL
===================

# rtc_bus_engine

Bus-cycle engine between the RTC control logic and the V3023 pins. Given one request, it runs a full multiplexed-bus transaction: an address phase, then a data phase that either writes or reads. It drives AD/CS/RD/WR and the tri-state data bus controls with programmable phase timing. It returns read data with a one-cycle done pulse, and replaces the ad-hoc per-programmer strobe generation feeding DATO_RTC.

## Interface
Parameters:
- T_SETUP, 2: cycles that address/data is stable before the strobe falls (1..255)
- T_PULSE, 10: cycles the strobe (WR or RD) is held low (1..255)
- T_HOLD, 2: cycles after the strobe rises before CS is released (1..255)
- T_GAP, 4: cycles with CS high between the address phase and the data phase (1..255)

Ports:
- CLOCK  in  1  system clock, 100 MHz
- RESET  in  1  asynchronous, active-low reset
- req  in  1  transaction request; sampled only in IDLE
- we  in  1  1 = write data phase, 0 = read data phase
- addr  in  8  RTC register address
- wdata  in  8  write data
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse at the end of a transaction
- rdata  out  8  last read byte; held until the next read completes
- bus_o  out  8  value to drive on DATO_RTC
- bus_oe  out  1  tri-state enable for DATO_RTC; the top level builds the tri-state
- bus_i  in  8  DATO_RTC input
- AD  out  1  0 = address phase, 1 = data phase
- CS, RD, WR  out  1 each  active-low RTC strobes
- IRQ  in  1  RTC interrupt (RTC_BUS_IRQ_EN only)
- irq_pulse  out  1  one-cycle pulse on a synchronized IRQ falling edge (RTC_BUS_IRQ_EN only)

## Operation
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, FIN.
- Phase counter: 8 bits, loaded with the phase length minus 1, decrements each cycle; the state advances when it reaches 0.
- IDLE:
  - req=1 latches addr, wdata and we, then enters A_SETUP.
  - req=0 keeps the state; req while busy is ignored (not queued).
- Address phase:
  - A_SETUP: AD=0, CS=0, bus_oe=1, bus_o=addr.
  - A_STROBE: additionally WR=0.
  - A_HOLD: WR=1, bus still driven.
- GAP: CS=1, bus_oe=0, AD=1.
- Data phase, write: CS=0, AD=1, bus_oe=1, bus_o=wdata throughout; WR=0 in D_STROBE.
- Data phase, read: bus_oe=0 throughout; RD=0 in D_STROBE; rdata captures bus_i on the last D_STROBE cycle.
- FIN: CS=1, AD=1, bus_oe=0, done=1, busy=0; returns to IDLE next cycle.
- Invariants:
  - RD and WR are never low together.
  - bus_oe is never 1 while RD=0.
  - CS is high whenever the state is IDLE, GAP or FIN.

## Timing
- Reset values: busy=0, done=0, rdata=0x00, bus_o=0x00, bus_oe=0, AD=1, CS=1, RD=1, WR=1, irq_pulse=0.
- busy rises the cycle after req is sampled.
- done pulses exactly 2·(T_SETUP+T_PULSE+T_HOLD)+T_GAP+1 cycles after the acceptance edge; the defaults give 33.
- rdata is valid in the done cycle.
- Back-to-back operation: req held high in the FIN→IDLE cycle is accepted in IDLE. The minimum spacing is therefore one IDLE cycle between transactions.
- RESET asserted mid-transaction forces all outputs to their reset values immediately (asynchronously). No partial strobe completes after release, and the engine restarts in IDLE.
- All outputs are registered; no combinational path from req to the strobes.

## Configuration
- RTC_BUS_IRQ_EN defined:
  - Adds the IRQ input, a two-flop synchronizer, and an edge detector.
  - irq_pulse fires one cycle per falling edge of the synchronized IRQ, 3 cycles after the pin falls.
  - It fires independently of transaction state.
- RTC_BUS_IRQ_EN undefined: IRQ and irq_pulse ports are absent and no synchronizer logic is built.

## Structure
- Shared package rtc_pkg holds:
  - the state encoding constants (4-bit);
  - the V3023 register address constants (seconds 0x21 … year 0x26, timer 0x41–0x43, command 0xF0–0xF2);
  - default timing constants.
- One sub-module, rtc_irq_sync (synchronizer plus falling-edge detector), instantiated only under RTC_BUS_IRQ_EN.

## Test plan
- Write, addr=0x21, wdata=0x45, defaults:
  - WR low exactly 10 cycles with bus_o=0x21 and AD=0;
  - then WR low 10 cycles with bus_o=0x45 and AD=1;
  - done at cycle 33; CS high through GAP.
- Read, addr=0x23, bus model returns 0x12 while RD=0:
  - rdata=0x12 at done;
  - bus_oe=0 for the whole data phase;
  - WR stays high in the data phase.
- req pulsed again at cycle 5 of a transaction: ignored, exactly one done pulse. req held high continuously: a second transaction starts one IDLE cycle after FIN.
- RESET driven low during D_STROBE of a write: WR, CS and bus_oe go inactive without waiting for a clock edge; after release, a new req completes normally.
- Parameters T_SETUP=1, T_PULSE=1, T_HOLD=1, T_GAP=1: done at cycle 8, every strobe exactly 1 cycle.
- With RTC_BUS_IRQ_EN, IRQ falls mid-read: irq_pulse is high for 1 cycle, 3 cycles later, and the read result is unaffected.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the V3023 RTC bus engine: state encoding, RTC register
// map and default phase timing.
package rtc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_A_SETUP  = 4'd1,
    ST_A_STROBE = 4'd2,
    ST_A_HOLD   = 4'd3,
    ST_GAP      = 4'd4,
    ST_D_SETUP  = 4'd5,
    ST_D_STROBE = 4'd6,
    ST_D_HOLD   = 4'd7,
    ST_FIN      = 4'd8
  } rtc_state_e;

  // V3023 register map
  localparam logic [7:0] RTC_REG_SEC    = 8'h21;
  localparam logic [7:0] RTC_REG_MIN    = 8'h22;
  localparam logic [7:0] RTC_REG_HOUR   = 8'h23;
  localparam logic [7:0] RTC_REG_DAY    = 8'h24;
  localparam logic [7:0] RTC_REG_MONTH  = 8'h25;
  localparam logic [7:0] RTC_REG_YEAR   = 8'h26;
  localparam logic [7:0] RTC_REG_TMR0   = 8'h41;
  localparam logic [7:0] RTC_REG_TMR1   = 8'h42;
  localparam logic [7:0] RTC_REG_TMR2   = 8'h43;
  localparam logic [7:0] RTC_REG_CMD0   = 8'hF0;
  localparam logic [7:0] RTC_REG_CMD1   = 8'hF1;
  localparam logic [7:0] RTC_REG_CMD2   = 8'hF2;

  localparam int RTC_T_SETUP_DEF = 2;
  localparam int RTC_T_PULSE_DEF = 10;
  localparam int RTC_T_HOLD_DEF  = 2;
  localparam int RTC_T_GAP_DEF   = 4;

endpackage

// File: rtl/rtc_irq_sync.sv
// Two-flop synchronizer for the RTC IRQ pin plus a falling-edge detector that
// emits a one-cycle pulse three clocks after the pin falls.
module rtc_irq_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  output logic pulse_o
);

  // [0],[1] are the synchronizer; [2] is the previous synchronized value
  logic [2:0] sync_q;
  logic       pulse_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 3'b111;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], irq_i};
      pulse_q <= sync_q[2] & ~sync_q[1];
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/rtc_bus_engine.sv
// Multiplexed-bus cycle engine for the V3023 RTC: address phase, gap, then a
// write or read data phase. Define RTC_BUS_IRQ_EN to add IRQ sync and irq_pulse.
module rtc_bus_engine
  import rtc_pkg::*;
#(
  parameter int T_SETUP = RTC_T_SETUP_DEF,
  parameter int T_PULSE = RTC_T_PULSE_DEF,
  parameter int T_HOLD  = RTC_T_HOLD_DEF,
  parameter int T_GAP   = RTC_T_GAP_DEF
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] bus_o,
  output logic       bus_oe,
  input  logic [7:0] bus_i,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       WR
`ifdef RTC_BUS_IRQ_EN
  ,
  input  logic       IRQ,
  output logic       irq_pulse
`endif
);

  localparam logic [7:0] LEN_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] LEN_PULSE = 8'(T_PULSE - 1);
  localparam logic [7:0] LEN_HOLD  = 8'(T_HOLD - 1);
  localparam logic [7:0] LEN_GAP   = 8'(T_GAP - 1);

  rtc_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       we_q;
  logic [7:0] addr_q, wdata_q;

  logic       busy_q, busy_d, done_q, done_d;
  logic       ad_q, ad_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic       oe_q, oe_d;
  logic [7:0] bo_q, bo_d, rdata_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  // Each phase loads its length-1 and advances once the counter hits zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (req) begin
        state_d = ST_A_SETUP;
        cnt_d   = LEN_SETUP;
      end
    end else if (state_q == ST_FIN) begin
      state_d = ST_IDLE;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      unique case (state_q)
        ST_A_SETUP:  begin state_d = ST_A_STROBE; cnt_d = LEN_PULSE; end
        ST_A_STROBE: begin state_d = ST_A_HOLD;   cnt_d = LEN_HOLD;  end
        ST_A_HOLD:   begin state_d = ST_GAP;      cnt_d = LEN_GAP;   end
        ST_GAP:      begin state_d = ST_D_SETUP;  cnt_d = LEN_SETUP; end
        ST_D_SETUP:  begin state_d = ST_D_STROBE; cnt_d = LEN_PULSE; end
        ST_D_STROBE: begin state_d = ST_D_HOLD;   cnt_d = LEN_HOLD;  end
        ST_D_HOLD:   begin state_d = ST_FIN;      cnt_d = 8'd0;      end
        default:     begin state_d = ST_IDLE;     cnt_d = 8'd0;      end
      endcase
    end
  end

  // Pin levels decoded from the current state, registered one cycle later
  always_comb begin
    busy_d = 1'b1;
    done_d = 1'b0;
    ad_d   = 1'b1;
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    oe_d   = 1'b0;
    bo_d   = 8'h00;
    unique case (state_q)
      ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
        ad_d = 1'b0;
        cs_d = 1'b0;
        oe_d = 1'b1;
        bo_d = addr_q;
        wr_d = (state_q != ST_A_STROBE);
      end
      ST_GAP: ;
      ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
        cs_d = 1'b0;
        if (we_q) begin
          oe_d = 1'b1;
          bo_d = wdata_q;
          wr_d = (state_q != ST_D_STROBE);
        end else begin
          rd_d = (state_q != ST_D_STROBE);
        end
      end
      ST_FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ad_q    <= 1'b1;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
      bo_q    <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      ad_q   <= ad_d;
      cs_q   <= cs_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      oe_q   <= oe_d;
      bo_q   <= bo_d;
      // sample on the last cycle RD is low, just as it is about to rise
      if (!rd_q && rd_d) rdata_q <= bus_i;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign bus_o  = bo_q;
  assign bus_oe = oe_q;
  assign AD     = ad_q;
  assign CS     = cs_q;
  assign RD     = rd_q;
  assign WR     = wr_q;

`ifdef RTC_BUS_IRQ_EN
  rtc_irq_sync u_irq_sync (
    .clk_i  (CLOCK),
    .rst_ni (RESET),
    .irq_i  (IRQ),
    .pulse_o(irq_pulse)
  );
`endif

endmodule
